hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed hazard detector in the five-stage ARM core.
- Tracks in-flight register writes across NUM_STAGES post-decode slots (EXE, MEM, WB for the default depth).
- Produces the ID-stage stall (`hazard_detected`) and per-operand forwarding selects.
- Adds runtime forwarding enable, load-use detection, a global hold, flush bubbles and a saturating stall counter.

---
 rtl/hazard_scoreboard_pkg.sv | 30 +++
 rtl/hazard_src_match.sv | 80 ++++++++
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared pipeline definitions for the hazard scoreboard and its operand
// matcher: the per-slot state record, the forwarding-select encoding of the
// register-file source, and the global register-file / datapath sizes.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

   // Global core settings, shared with the rest of the pipeline.
   localparam int REG_FILE_DEPTH = 16;
   localparam int WORD_WIDTH     = 32;

   // Slot destination field is sized for the widest supported register
   // address; narrower REG_ADDR_W values are zero-extended on entry.
   localparam int SLOT_DST_W     = 8;

   // Forwarding select value meaning "read the register file".
   localparam int FWD_SRC_RF     = 0;

   // One tracked in-flight instruction.
   typedef struct packed {
      logic                  v;    // slot holds a real instruction
      logic [SLOT_DST_W-1:0] dst;  // destination register
      logic                  wb;   // instruction writes dst
      logic                  ld;   // instruction is a load
   } slot_t;

   localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hazard_src_match.sv
// -----------------------------------------------------------------------------
// hazard_src_match
// Compares one ID-stage source operand against every tracked slot and reports
// whether that operand forces a stall and, with forwarding on, which slot
// should supply it (youngest producer wins).
//
// Ports:
//   src       in  REG_ADDR_W   source register address
//   has_src   in  1            source is actually read
//   slots     in  slot_t[N]    tracked slots, index 0 = EXE (youngest)
//   fwd_on    in  1            forwarding active this cycle
//   stall_hit out 1            this operand needs a stall
//   fwd_sel   out SEL_W        0 = register file, k = slot k-1
// -----------------------------------------------------------------------------
module hazard_src_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W       = 4,
   parameter int NUM_STAGES       = 3,
   parameter int FWD_EN           = 1,
   parameter int RF_WRITE_THROUGH = 1,
   parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
   input  logic [REG_ADDR_W-1:0]   src,
   input  logic                    has_src,
   input  slot_t [NUM_STAGES-1:0]  slots,
   input  logic                    fwd_on,
   output logic                    stall_hit,
   output logic [SEL_W-1:0]        fwd_sel
);

   // With a write-through register file the WB slot is readable this cycle.
   localparam int STALL_SLOTS = (RF_WRITE_THROUGH != 0) ? NUM_STAGES - 1 : NUM_STAGES;

   logic [NUM_STAGES-1:0] match;
   logic                  unused_ld;

   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      match     = '0;
      unused_ld = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         match[k] = has_src & slots[k].v & slots[k].wb &
                    (slots[k].dst == SLOT_DST_W'(src));
      end
      // Only the EXE slot's load flag matters for load-use detection.
      for (int k = 1; k < NUM_STAGES; k++) begin
         unused_ld = unused_ld ^ slots[k].ld;
      end
   end

   always_comb begin
      stall_hit = 1'b0;
      if (fwd_on) begin
         stall_hit = match[0] & slots[0].ld;
      end else begin
         for (int k = 0; k < STALL_SLOTS; k++) begin
            if (match[k]) stall_hit = 1'b1;
         end
      end
   end

   generate
      if (FWD_EN != 0) begin : g_fwd
         // Scan oldest to youngest so the youngest matching slot is kept.
         always_comb begin
            fwd_sel = SEL_W'(FWD_SRC_RF);
            if (fwd_on) begin
               for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                  if (match[k]) fwd_sel = SEL_W'(k + 1);
               end
            end
         end
      end else begin : g_no_fwd
         assign fwd_sel = SEL_W'(FWD_SRC_RF);
      end
   endgenerate

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks in-flight register writes across NUM_STAGES post-decode slots and
// produces the ID-stage stall plus per-operand forwarding selects. Supports
// runtime forwarding enable, load-use detection, global hold, flush bubbles
// and a saturating stall-cycle counter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_valid            ID stage holds a real instruction
//   id_src1/id_src2     source addresses, qualified by id_has_src1/2
//   id_dst, id_wb_en    destination and write enable of the ID instruction
//   id_mem_read         ID instruction is a load
//   flush               ID instruction is discarded (branch taken in EXE)
//   hold                freeze all state (memory wait)
//   fwd_en              runtime forwarding enable (ignored when FWD_EN=0)
//   hazard_detected     stall IF/ID and insert a bubble
//   fwd_sel1/fwd_sel2   operand source, 0 = register file, k = slot k-1
//   stage_valid         per-slot valid bits
//   stall_count         saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W       = 4,
   parameter int NUM_STAGES       = 3,
   parameter int FWD_EN           = 1,
   parameter int RF_WRITE_THROUGH = 1,
   parameter int CNT_W            = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              id_valid,
   input  logic [REG_ADDR_W-1:0]             id_src1,
   input  logic [REG_ADDR_W-1:0]             id_src2,
   input  logic                              id_has_src1,
   input  logic                              id_has_src2,
   input  logic [REG_ADDR_W-1:0]             id_dst,
   input  logic                              id_wb_en,
   input  logic                              id_mem_read,
   input  logic                              flush,
   input  logic                              hold,
   input  logic                              fwd_en,
   output logic                              hazard_detected,
   output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel1,
   output logic [$clog2(NUM_STAGES+1)-1:0]   fwd_sel2,
   output logic [NUM_STAGES-1:0]             stage_valid,
   output logic [CNT_W-1:0]                  stall_count
);

   localparam int SEL_W = $clog2(NUM_STAGES + 1);

   slot_t [NUM_STAGES-1:0] slots;
   logic                   fwd_on;
   logic                   hit1, hit2;
   logic [SEL_W-1:0]       sel1_raw, sel2_raw;
   logic                   issue;

   assign fwd_on = (FWD_EN != 0) && fwd_en;

   hazard_src_match #(
      .REG_ADDR_W       (REG_ADDR_W),
      .NUM_STAGES       (NUM_STAGES),
      .FWD_EN           (FWD_EN),
      .RF_WRITE_THROUGH (RF_WRITE_THROUGH),
      .SEL_W            (SEL_W)
   ) u_match_src1 (
      .src       (id_src1),
      .has_src   (id_has_src1),
      .slots     (slots),
      .fwd_on    (fwd_on),
      .stall_hit (hit1),
      .fwd_sel   (sel1_raw)
   );

   hazard_src_match #(
      .REG_ADDR_W       (REG_ADDR_W),
      .NUM_STAGES       (NUM_STAGES),
      .FWD_EN           (FWD_EN),
      .RF_WRITE_THROUGH (RF_WRITE_THROUGH),
      .SEL_W            (SEL_W)
   ) u_match_src2 (
      .src       (id_src2),
      .has_src   (id_has_src2),
      .slots     (slots),
      .fwd_on    (fwd_on),
      .stall_hit (hit2),
      .fwd_sel   (sel2_raw)
   );

   assign hazard_detected = id_valid & (hit1 | hit2);

   // A stalled or empty ID slot must not steer the operand muxes.
   assign fwd_sel1 = (id_valid & ~hazard_detected) ? sel1_raw : SEL_W'(FWD_SRC_RF);
   assign fwd_sel2 = (id_valid & ~hazard_detected) ? sel2_raw : SEL_W'(FWD_SRC_RF);

   assign issue = id_valid & ~hazard_detected & ~flush;

   always_comb begin
      stage_valid = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         stage_valid[k] = slots[k].v;
      end
   end

   // NOTE: the slot array is a handful of flops, not a RAM, so every slot is
   // cleared on reset; the valid bits must be known before the first match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so the shift
         // below reads every slot's pre-edge value regardless of loop order.
         slots <= '0;
      end else if (!hold) begin
         for (int k = 1; k < NUM_STAGES; k++) begin
            slots[k] <= slots[k-1];
         end
         slots[0] <= issue ? '{v: 1'b1, dst: SLOT_DST_W'(id_dst),
                               wb: id_wb_en, ld: id_mem_read}
                           : SLOT_BUBBLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (!hold && hazard_detected && !flush && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Table-driven bench for hazard_scoreboard (default depth, forwarding built
// in, write-through register file, 2-bit stall counter so saturation is
// reachable). Each row carries hand-derived hazard / select values; slot
// valid bits and the stall counter come from a small reference model.
// Expected records are queued when a row is driven and popped when the DUT
// outputs are sampled. Hand-written sequences cover reset state and an
// asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int N_ROWS = 28;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [3:0] id_src1, id_src2, id_dst;
   logic       id_has_src1, id_has_src2;
   logic       id_wb_en, id_mem_read;
   logic       flush, hold, fwd_en;
   logic       hazard_detected;
   logic [1:0] fwd_sel1, fwd_sel2;
   logic [2:0] stage_valid;
   logic [1:0] stall_count;

   hazard_scoreboard #(
      .REG_ADDR_W       (4),
      .NUM_STAGES       (3),
      .FWD_EN           (1),
      .RF_WRITE_THROUGH (1),
      .CNT_W            (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_has_src1     (id_has_src1),
      .id_has_src2     (id_has_src2),
      .id_dst          (id_dst),
      .id_wb_en        (id_wb_en),
      .id_mem_read     (id_mem_read),
      .flush           (flush),
      .hold            (hold),
      .fwd_en          (fwd_en),
      .hazard_detected (hazard_detected),
      .fwd_sel1        (fwd_sel1),
      .fwd_sel2        (fwd_sel2),
      .stage_valid     (stage_valid),
      .stall_count     (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [3:0] s1;
      logic       h1;
      logic [3:0] s2;
      logic       h2;
      logic [3:0] d;
      logic       wb;
      logic       ld;
      logic       fl;
      logic       ho;
      logic       fe;
      logic       e_hz;
      logic [1:0] e_s1;
      logic [1:0] e_s2;
   } vec_t;

   typedef struct {
      logic       hz;
      logic [1:0] s1;
      logic [1:0] s2;
      logic [2:0] sv;
      logic [1:0] cnt;
   } exp_t;

   vec_t tbl [N_ROWS];
   exp_t sb_q [$];

   // Reference model: slot valid bits and stall counter.
   logic [2:0] mv;
   int         mc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic h1,
                               input logic [3:0] s2, input logic h2, input logic [3:0] d,
                               input logic wb, input logic ld, input logic fl,
                               input logic ho, input logic fe, input logic e_hz,
                               input logic [1:0] e_s1, input logic [1:0] e_s2);
      vec_t r;
      r.v = v;   r.s1 = s1; r.h1 = h1; r.s2 = s2; r.h2 = h2; r.d = d;
      r.wb = wb; r.ld = ld; r.fl = fl; r.ho = ho; r.fe = fe;
      r.e_hz = e_hz; r.e_s1 = e_s1; r.e_s2 = e_s2;
      return r;
   endfunction

   task automatic drive(input vec_t r);
      id_valid    = r.v;
      id_src1     = r.s1;
      id_has_src1 = r.h1;
      id_src2     = r.s2;
      id_has_src2 = r.h2;
      id_dst      = r.d;
      id_wb_en    = r.wb;
      id_mem_read = r.ld;
      flush       = r.fl;
      hold        = r.ho;
      fwd_en      = r.fe;
   endtask

   task automatic apply_row(input int i);
      vec_t       r;
      exp_t       e;
      exp_t       got;
      logic [2:0] nv;
      int         nc;
      r = tbl[i];
      @(negedge clk);
      drive(r);
      #1;
      e.hz  = r.e_hz;
      e.s1  = r.e_s1;
      e.s2  = r.e_s2;
      e.sv  = mv;
      e.cnt = 2'(mc);
      sb_q.push_back(e);
      got = sb_q.pop_front();
      check($sformatf("row%0d hazard", i),      32'(hazard_detected), 32'(got.hz));
      check($sformatf("row%0d fwd_sel1", i),    32'(fwd_sel1),        32'(got.s1));
      check($sformatf("row%0d fwd_sel2", i),    32'(fwd_sel2),        32'(got.s2));
      check($sformatf("row%0d stage_valid", i), 32'(stage_valid),     32'(got.sv));
      check($sformatf("row%0d stall_count", i), 32'(stall_count),     32'(got.cnt));
      nv = mv;
      nc = mc;
      if (!r.ho) begin
         nv = {mv[1], mv[0], r.v & ~r.e_hz & ~r.fl};
         if (r.e_hz && !r.fl && mc < 3) nc = mc + 1;
      end
      @(posedge clk);
      mv = nv;
      mc = nc;
   endtask

   initial begin
      //           v s1 h1 s2 h2  d wb ld fl ho fe  hz s1 s2
      tbl[0]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0); // ADD r3
      tbl[1]  = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 1, 0); // r3 from EXE
      tbl[2]  = mk(1, 3, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 2, 0); // r3 from MEM
      tbl[3]  = mk(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 3, 2); // r3 WB, r4 MEM
      tbl[4]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0); // LDR r5
      tbl[5]  = mk(1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 1, 1, 0, 0); // load-use
      tbl[6]  = mk(1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 1, 0, 0, 2); // resolved
      tbl[7]  = mk(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, 1, 0);
      tbl[8]  = mk(1, 7, 1, 7, 1, 9, 1, 0, 0, 0, 1, 0, 1, 1); // r7 twice: youngest
      tbl[9]  = mk(1, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0); // fwd off, r7 slot 1
      tbl[10] = mk(1, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); // fwd off, r7 slot 2
      tbl[11] = mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0); // bubble dst=0
      tbl[12] = mk(1, 2, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0); // has-bits clear
      tbl[13] = mk(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); // id_valid=0
      tbl[14] = mk(1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 1, 0, 2, 0); // flush
      tbl[15] = mk(1, 3, 1, 0, 0, 5, 1, 0, 1, 1, 1, 0, 3, 0); // hold + flush
      tbl[16] = mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 1, 0, 0, 0); // LDR r8
      tbl[17] = mk(1, 8, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0); // stall under hold
      tbl[18] = mk(1, 8, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0); // stall under flush
      tbl[19] = mk(1, 8, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2, 0);
      tbl[20] = mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0); // count -> 3
      tbl[21] = mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0); // saturated
      tbl[22] = mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[23] = mk(1, 2, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0, 0); // still 3
      tbl[24] = mk(1, 2, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 2, 0);
      tbl[25] = mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[26] = mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, 0, 0, 0);
      tbl[27] = mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1, 0, 0, 0); // slots all valid

      // Reset state: ID presents a read that would match nothing anyway.
      rst = 1'b1;
      drive(mk(1, 3, 1, 3, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0));
      mv = '0;
      mc = 0;
      repeat (2) @(negedge clk);
      #1;
      check("reset hazard",      32'(hazard_detected), 32'd0);
      check("reset fwd_sel1",    32'(fwd_sel1),        32'd0);
      check("reset fwd_sel2",    32'(fwd_sel2),        32'd0);
      check("reset stage_valid", 32'(stage_valid),     32'd0);
      check("reset stall_count", 32'(stall_count),     32'd0);
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < N_ROWS; i++) begin
         apply_row(i);
      end

      // Asynchronous reset mid-stream with a pending load-use hazard.
      @(negedge clk);
      drive(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      #1;
      check("pre-rst hazard",      32'(hazard_detected), 32'd1);
      check("pre-rst stage_valid", 32'(stage_valid),     32'(mv));
      check("pre-rst stall_count", 32'(stall_count),     32'(mc));
      #1;
      rst = 1'b1;
      #1;
      check("async-rst stage_valid", 32'(stage_valid),     32'd0);
      check("async-rst hazard",      32'(hazard_detected), 32'd0);
      check("async-rst stall_count", 32'(stall_count),     32'd0);
      check("async-rst fwd_sel1",    32'(fwd_sel1),        32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-rst fwd_sel1", 32'(fwd_sel1), 32'd0);

      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
